// File: rtl/riscv_rf_scoreboard_if.sv
// Issue, dual writeback, register-file write port and status signals of the scoreboard.
// RISCV_RF_SCOREBOARD_FWD_EN adds the forwarding outputs.
interface riscv_rf_scoreboard_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
);
  logic              issue_valid_i;
  logic              issue_ready_o;
  logic [ADDR_W-1:0] issue_rs1_i;
  logic [ADDR_W-1:0] issue_rs2_i;
  logic [ADDR_W-1:0] issue_rd_i;
  logic              issue_rd_we_i;
  logic              wb0_valid_i;
  logic [ADDR_W-1:0] wb0_addr_i;
  logic [DATA_W-1:0] wb0_data_i;
  logic              wb0_ready_o;
  logic              wb1_valid_i;
  logic [ADDR_W-1:0] wb1_addr_i;
  logic [DATA_W-1:0] wb1_data_i;
  logic              wb1_ready_o;
  logic [ADDR_W-1:0] AddrD_o;
  logic [DATA_W-1:0] DataD_o;
  logic              RegWEn_o;
  logic [3:0]        outstanding_o;
  logic              err_o;
`ifdef RISCV_RF_SCOREBOARD_FWD_EN
  logic              fwd_a_o;
  logic              fwd_b_o;
  logic [DATA_W-1:0] fwd_data_o;
`endif

  modport slave (
    input  issue_valid_i, issue_rs1_i, issue_rs2_i, issue_rd_i, issue_rd_we_i,
    input  wb0_valid_i, wb0_addr_i, wb0_data_i, wb1_valid_i, wb1_addr_i, wb1_data_i,
    output issue_ready_o, wb0_ready_o, wb1_ready_o,
    output AddrD_o, DataD_o, RegWEn_o, outstanding_o, err_o
`ifdef RISCV_RF_SCOREBOARD_FWD_EN
    , output fwd_a_o, fwd_b_o, fwd_data_o
`endif
  );

  modport master (
    output issue_valid_i, issue_rs1_i, issue_rs2_i, issue_rd_i, issue_rd_we_i,
    output wb0_valid_i, wb0_addr_i, wb0_data_i, wb1_valid_i, wb1_addr_i, wb1_data_i,
    input  issue_ready_o, wb0_ready_o, wb1_ready_o,
    input  AddrD_o, DataD_o, RegWEn_o, outstanding_o, err_o
`ifdef RISCV_RF_SCOREBOARD_FWD_EN
    , input fwd_a_o, fwd_b_o, fwd_data_o
`endif
  );
endinterface

// File: rtl/riscv_rf_scoreboard.sv
// Register-file scoreboard: pending bits, hazard stall, outstanding limit, round-robin writeback.
// Define RISCV_RF_SCOREBOARD_FWD_EN to forward the committing write to the issue stage.
module riscv_rf_scoreboard #(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 5,
  parameter int MAX_OUT = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  riscv_rf_scoreboard_if.slave  bus
);
  localparam int         NREG      = 1 << ADDR_W;
  localparam logic [3:0] MAX_OUT_C = 4'(MAX_OUT);

  logic              pending_reg [NREG];
  logic              busy        [NREG];
  logic [3:0]        outstanding_reg, outstanding_next;
  logic              last_grant_reg;
  logic [ADDR_W-1:0] addr_reg;
  logic [DATA_W-1:0] data_reg;
  logic              wen_reg;
  logic              err_reg;

  logic              haz, issue_fire, set_en, clr_en, dec_en;
  logic              grant0, grant1, grant_any;
  logic [ADDR_W-1:0] grant_addr;
  logic [DATA_W-1:0] grant_data;

  // The write on AddrD this cycle retires its pending bit at the closing edge.
  assign clr_en     = wen_reg & pending_reg[addr_reg];
  assign dec_en     = clr_en & (outstanding_reg != 4'd0);
  assign haz        = busy[bus.issue_rs1_i] | busy[bus.issue_rs2_i]
                    | (bus.issue_rd_we_i & busy[bus.issue_rd_i]);
  assign issue_fire = bus.issue_valid_i & ~haz & (outstanding_reg < MAX_OUT_C);
  assign set_en     = issue_fire & bus.issue_rd_we_i & (bus.issue_rd_i != '0);

  genvar gi;
  generate
    for (gi = 0; gi < NREG; gi++) begin : g_pend
      if (gi == 0) begin : g_zero
        assign pending_reg[gi] = 1'b0;
        assign busy[gi]        = 1'b0;
      end else begin : g_bit
        logic set_hit, clr_hit;
        assign set_hit = set_en & (bus.issue_rd_i == ADDR_W'(gi));
        assign clr_hit = clr_en & (addr_reg == ADDR_W'(gi));
`ifdef RISCV_RF_SCOREBOARD_FWD_EN
        assign busy[gi] = pending_reg[gi] & ~(wen_reg & (addr_reg == ADDR_W'(gi)));
`else
        assign busy[gi] = pending_reg[gi];
`endif
        // Set has priority so a forwarded re-issue of the same rd stays pending.
        always_ff @(posedge clk_i or negedge rst_ni) begin
          if (!rst_ni)      pending_reg[gi] <= 1'b0;
          else if (set_hit) pending_reg[gi] <= 1'b1;
          else if (clr_hit) pending_reg[gi] <= 1'b0;
        end
      end
    end
  endgenerate

  always_comb begin
    outstanding_next = outstanding_reg;
    if (set_en & ~dec_en)      outstanding_next = outstanding_reg + 4'd1;
    else if (dec_en & ~set_en) outstanding_next = outstanding_reg - 4'd1;
  end

  // Contested cycles go to the source that did not win last time.
  assign grant0     = bus.wb0_valid_i & (~bus.wb1_valid_i | last_grant_reg);
  assign grant1     = bus.wb1_valid_i & (~bus.wb0_valid_i | ~last_grant_reg);
  assign grant_any  = grant0 | grant1;
  assign grant_addr = grant1 ? bus.wb1_addr_i : bus.wb0_addr_i;
  assign grant_data = grant1 ? bus.wb1_data_i : bus.wb0_data_i;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      outstanding_reg <= 4'd0;
      last_grant_reg  <= 1'b1;
      addr_reg        <= '0;
      data_reg        <= '0;
      wen_reg         <= 1'b0;
      err_reg         <= 1'b0;
    end else begin
      outstanding_reg <= outstanding_next;
      if (wen_reg & ~pending_reg[addr_reg]) err_reg <= 1'b1;
      if (grant_any) begin
        last_grant_reg <= grant1;
        addr_reg       <= grant_addr;
        data_reg       <= grant_data;
        wen_reg        <= (grant_addr != '0);
      end else begin
        wen_reg <= 1'b0;
      end
    end
  end

  assign bus.issue_ready_o = issue_fire;
  assign bus.wb0_ready_o   = grant0;
  assign bus.wb1_ready_o   = grant1;
  assign bus.AddrD_o       = addr_reg;
  assign bus.DataD_o       = data_reg;
  assign bus.RegWEn_o      = wen_reg;
  assign bus.outstanding_o = outstanding_reg;
  assign bus.err_o         = err_reg;
`ifdef RISCV_RF_SCOREBOARD_FWD_EN
  assign bus.fwd_a_o    = wen_reg & (bus.issue_rs1_i == addr_reg);
  assign bus.fwd_b_o    = wen_reg & (bus.issue_rs2_i == addr_reg);
  assign bus.fwd_data_o = data_reg;
`endif
endmodule

// File: tb/tb_riscv_rf_scoreboard.sv
// Bench for riscv_rf_scoreboard: directed scenarios plus random traffic against a cycle model.
module tb_riscv_rf_scoreboard;
  localparam int DATA_W  = 32;
  localparam int ADDR_W  = 5;
  localparam int MAX_OUT = 4;
  localparam int NREG    = 1 << ADDR_W;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   errors = 0;
  int   checks = 0;
  int   cyc    = 0;

  // Reference state: what the register file port and scoreboard should look like now.
  bit                m_pend [NREG];
  int                m_out;
  bit                m_last;
  bit                m_err;
  bit                m_wen;
  logic [ADDR_W-1:0] m_addr;
  logic [DATA_W-1:0] m_data;

  always #5 clk = ~clk;

  riscv_rf_scoreboard_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

  riscv_rf_scoreboard #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .MAX_OUT(MAX_OUT)) dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (bus)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic void model_reset();
    foreach (m_pend[r]) m_pend[r] = 1'b0;
    m_out  = 0;
    m_last = 1'b1;
    m_err  = 1'b0;
    m_wen  = 1'b0;
    m_addr = '0;
    m_data = '0;
  endfunction

  function automatic bit m_busy(logic [ADDR_W-1:0] r);
    if (r == '0) return 1'b0;
`ifdef RISCV_RF_SCOREBOARD_FWD_EN
    if (m_wen && m_addr == r) return 1'b0;
`endif
    return m_pend[r];
  endfunction

  task automatic drive_issue(bit v, int rs1, int rs2, int rd, bit we);
    bus.issue_valid_i = v;
    bus.issue_rs1_i   = ADDR_W'(rs1);
    bus.issue_rs2_i   = ADDR_W'(rs2);
    bus.issue_rd_i    = ADDR_W'(rd);
    bus.issue_rd_we_i = we;
  endtask

  task automatic drive_wb(bit v0, int a0, logic [DATA_W-1:0] d0, bit v1, int a1, logic [DATA_W-1:0] d1);
    bus.wb0_valid_i = v0;
    bus.wb0_addr_i  = ADDR_W'(a0);
    bus.wb0_data_i  = d0;
    bus.wb1_valid_i = v1;
    bus.wb1_addr_i  = ADDR_W'(a1);
    bus.wb1_data_i  = d1;
  endtask

  task automatic idle();
    drive_issue(1'b0, 0, 0, 0, 1'b0);
    drive_wb(1'b0, 0, '0, 1'b0, 0, '0);
  endtask

  // One clock: check all outputs mid-cycle against the model, then advance the model.
  task automatic step();
    bit rdy, g0, g1, v0, v1;
    @(negedge clk);
    rdy = bus.issue_valid_i
        && !(m_busy(bus.issue_rs1_i) || m_busy(bus.issue_rs2_i)
             || (bus.issue_rd_we_i && m_busy(bus.issue_rd_i)))
        && (m_out < MAX_OUT);
    v0 = bus.wb0_valid_i;
    v1 = bus.wb1_valid_i;
    if (v0 && v1) begin
      g0 = (m_last == 1'b1);
      g1 = (m_last == 1'b0);
    end else begin
      g0 = v0;
      g1 = v1;
    end
    check("issue_ready", bus.issue_ready_o, rdy);
    check("wb0_ready", bus.wb0_ready_o, g0);
    check("wb1_ready", bus.wb1_ready_o, g1);
    check("RegWEn", bus.RegWEn_o, m_wen);
    check("AddrD", bus.AddrD_o, m_addr);
    check("DataD", bus.DataD_o, m_data);
    check("outstanding", bus.outstanding_o, m_out);
    check("err", bus.err_o, m_err);
`ifdef RISCV_RF_SCOREBOARD_FWD_EN
    check("fwd_a", bus.fwd_a_o, m_wen && (m_addr == bus.issue_rs1_i));
    check("fwd_b", bus.fwd_b_o, m_wen && (m_addr == bus.issue_rs2_i));
    check("fwd_data", bus.fwd_data_o, m_data);
`endif
    $display("cyc %0d issue v=%0b rd=%0d rdy=%0b | wb0 %0b/%0b wb1 %0b/%0b | wen=%0b AddrD=%0d out=%0d err=%0b",
             cyc, bus.issue_valid_i, bus.issue_rd_i, bus.issue_ready_o, v0, bus.wb0_ready_o,
             v1, bus.wb1_ready_o, bus.RegWEn_o, bus.AddrD_o, bus.outstanding_o, bus.err_o);
    if (m_wen) begin
      if (m_pend[m_addr]) begin
        m_pend[m_addr] = 1'b0;
        if (m_out > 0) m_out--;
      end else begin
        m_err = 1'b1;
      end
    end
    if (rdy && bus.issue_rd_we_i && bus.issue_rd_i != '0) begin
      m_pend[bus.issue_rd_i] = 1'b1;
      m_out++;
    end
    if (g0 || g1) begin
      m_last = g1;
      m_addr = g1 ? bus.wb1_addr_i : bus.wb0_addr_i;
      m_data = g1 ? bus.wb1_data_i : bus.wb0_data_i;
      m_wen  = (m_addr != '0);
    end else begin
      m_wen = 1'b0;
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic do_reset();
    idle();
    rst_n = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int pend_q[$];
    int a0, a1;
    idle();
    do_reset();
    check("rst_RegWEn", bus.RegWEn_o, 1'b0);
    check("rst_AddrD", bus.AddrD_o, 0);
    check("rst_DataD", bus.DataD_o, 0);
    check("rst_outstanding", bus.outstanding_o, 0);
    check("rst_err", bus.err_o, 1'b0);

    // RAW stall and release after commit
    drive_issue(1'b1, 0, 0, 5, 1'b1);
    step();
    drive_issue(1'b1, 5, 0, 6, 1'b1);
    #1 check("raw_stall", bus.issue_ready_o, 1'b0);
    step();
    drive_wb(1'b1, 5, 32'hDEADBEEF, 1'b0, 0, '0);
    #1 check("raw_wb0_grant", bus.wb0_ready_o, 1'b1);
    step();
    drive_wb(1'b0, 0, '0, 1'b0, 0, '0);
    #1 check("raw_commit_wen", bus.RegWEn_o, 1'b1);
    check("raw_commit_addr", bus.AddrD_o, 5);
`ifdef RISCV_RF_SCOREBOARD_FWD_EN
    check("raw_fwd_issue", bus.issue_ready_o, 1'b1);
    check("raw_fwd_a", bus.fwd_a_o, 1'b1);
    check("raw_fwd_data", bus.fwd_data_o, 32'hDEADBEEF);
    step();
`else
    check("raw_commit_stall", bus.issue_ready_o, 1'b0);
    step();
    #1 check("raw_release", bus.issue_ready_o, 1'b1);
    step();
`endif
    idle();
    step();

    // Outstanding limit
    do_reset();
    for (int r = 1; r <= 4; r++) begin
      drive_issue(1'b1, 0, 0, r, 1'b1);
      step();
    end
    drive_issue(1'b1, 0, 0, 6, 1'b1);
    #1 check("max_count", bus.outstanding_o, 4);
    check("max_stall", bus.issue_ready_o, 1'b0);
    drive_wb(1'b1, 1, $urandom, 1'b0, 0, '0);
    step();
    drive_wb(1'b0, 0, '0, 1'b0, 0, '0);
    #1 check("max_commit_stall", bus.issue_ready_o, 1'b0);
    step();
    #1 check("max_accept", bus.issue_ready_o, 1'b1);
    step();
    idle();
    #1 check("max_refill", bus.outstanding_o, 4);
    step();

    // Round-robin alternation
    do_reset();
    drive_issue(1'b1, 0, 0, 7, 1'b1);
    step();
    drive_issue(1'b1, 0, 0, 8, 1'b1);
    step();
    drive_issue(1'b0, 0, 0, 0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      drive_wb(1'b1, 7, $urandom, 1'b1, 8, $urandom);
      #1 check("alt_g0", bus.wb0_ready_o, (i % 2) == 0);
      check("alt_g1", bus.wb1_ready_o, (i % 2) == 1);
      step();
    end
    idle();
    #1 check("alt_last_wen", bus.RegWEn_o, 1'b1);
    check("alt_last_addr", bus.AddrD_o, 8);
    step();

    // x0 issue and writeback
    do_reset();
    drive_issue(1'b1, 0, 0, 0, 1'b1);
    drive_wb(1'b1, 0, 32'h1234, 1'b0, 0, '0);
    #1 check("x0_ready", bus.issue_ready_o, 1'b1);
    check("x0_grant", bus.wb0_ready_o, 1'b1);
    step();
    idle();
    #1 check("x0_wen", bus.RegWEn_o, 1'b0);
    check("x0_count", bus.outstanding_o, 0);
    step();

    // Writeback to a non-pending register
    do_reset();
    drive_wb(1'b1, 9, 32'hA5A50009, 1'b0, 0, '0);
    step();
    idle();
    #1 check("err_wen", bus.RegWEn_o, 1'b1);
    check("err_addr", bus.AddrD_o, 9);
    step();
    #1 check("err_set", bus.err_o, 1'b1);
    for (int i = 0; i < 4; i++) begin
      drive_issue(1'b1, 0, 0, 10 + i, 1'b1);
      drive_wb(i[0], 10, $urandom, 1'b0, 0, '0);
      step();
    end
    idle();
    #1 check("err_sticky", bus.err_o, 1'b1);
    step();

    // Asynchronous reset with work in flight
    do_reset();
    check("err_cleared", bus.err_o, 1'b0);
    for (int r = 1; r <= 3; r++) begin
      drive_issue(1'b1, 0, 0, r, 1'b1);
      step();
    end
    drive_issue(1'b0, 0, 0, 0, 1'b0);
    drive_wb(1'b1, 1, $urandom, 1'b0, 0, '0);
    step();
    drive_wb(1'b1, 2, $urandom, 1'b0, 0, '0);
    #3 rst_n = 1'b0;
    #1 check("arst_wen", bus.RegWEn_o, 1'b0);
    check("arst_count", bus.outstanding_o, 0);
    check("arst_AddrD", bus.AddrD_o, 0);
    check("arst_DataD", bus.DataD_o, 0);
    model_reset();
    @(posedge clk);
    #2;
    idle();
    rst_n = 1'b1;
    drive_issue(1'b1, 1, 0, 10, 1'b1);
    #1 check("arst_issue", bus.issue_ready_o, 1'b1);
    check("arst_no_write", bus.RegWEn_o, 1'b0);
    step();
    idle();
    step();

    // Random traffic
    do_reset();
    for (int n = 0; n < 400; n++) begin
      pend_q = {};
      for (int r = 1; r < NREG; r++) if (m_pend[r]) pend_q.push_back(r);
      drive_issue($urandom_range(0, 9) < 7, $urandom_range(0, 7), $urandom_range(0, 7),
                  $urandom_range(0, 7), $urandom_range(0, 1) == 1);
      a0 = (pend_q.size() > 0 && $urandom_range(0, 3) != 0)
         ? pend_q[$urandom_range(0, pend_q.size() - 1)] : int'($urandom_range(0, 15));
      a1 = (pend_q.size() > 0 && $urandom_range(0, 3) != 0)
         ? pend_q[$urandom_range(0, pend_q.size() - 1)] : int'($urandom_range(0, 15));
      drive_wb($urandom_range(0, 9) < 4, a0, $urandom, $urandom_range(0, 9) < 4, a1, $urandom);
      step();
    end
    idle();
    step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
